// File: rtl/spc7110_bank_map.sv
// SPC7110 bank-switching address mapper: $C0-$FF ROM windows, battery SRAM window,
// I/O-mapped bank registers with an MCU request/ack write port, one-cycle registered decode.
module spc7110_bank_map #(
    parameter int          NWIN    = 4,
    parameter int          BANK_W  = 3,
    parameter logic [15:0] IO_BASE = 16'h4830,
    parameter bit          FIX_W0  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [23:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic        SNES_WR_PULSE,
    input  logic        SNES_RD_PULSE,
    input  logic [23:0] ROM_MASK,
    input  logic [23:0] SAVERAM_MASK,
    input  logic        mcu_wr_req,
    input  logic [3:0]  mcu_wr_idx,
    input  logic [7:0]  mcu_wr_data,
    output logic        mcu_wr_ack,
    output logic [23:0] ROM_ADDR,
    output logic        ROM_HIT,
    output logic        IS_SAVERAM,
    output logic        reg_rd_hit,
    output logic [7:0]  SNES_DATA_OUT
);

    localparam int          WSEL_W   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int          WOFF_W   = 22 - $clog2(NWIN);
    localparam logic [23:0] OFF_MASK = (24'd1 << WOFF_W) - 24'd1;
    localparam logic [15:0] IO_LAST  = IO_BASE + 16'(NWIN);

    logic [7:0]        ctrl_r;
    logic [BANK_W-1:0] bank_r [NWIN];
    logic              ack_r;
    logic [23:0]       rom_addr_r;
    logic              rom_hit_r;
    logic              is_saveram_r;
    logic              reg_rd_hit_r;
    logic [7:0]        data_out_r;

    logic              reg_sel_s;
    logic [3:0]        reg_off_s;
    logic              snes_reg_wr_s;
    logic              mcu_commit_s;
    logic              wr_en_s;
    logic [3:0]        wr_idx_s;
    logic [7:0]        wr_data_s;
    logic [7:0]        rd_val_s;
    logic [WSEL_W-1:0] win_s;
    logic [BANK_W-1:0] rom_bank_s;
    logic              in_rom_s;
    logic              in_sram_s;
    logic [23:0]       rom_map_s;
    logic [23:0]       sram_map_s;

    // Register address decode and arbitration of the single register-file write port
    always_comb begin
        reg_sel_s     = !SNES_ADDR[22] && (SNES_ADDR[15:0] >= IO_BASE) && (SNES_ADDR[15:0] <= IO_LAST);
        reg_off_s     = 4'(SNES_ADDR[15:0] - IO_BASE);
        snes_reg_wr_s = SNES_WR_PULSE && reg_sel_s;
        // The SNES owns the port; a colliding MCU request simply waits with req held.
        mcu_commit_s  = mcu_wr_req && !ack_r && !snes_reg_wr_s;
        wr_en_s       = 1'b0;
        wr_idx_s      = 4'd0;
        wr_data_s     = 8'h00;
        if (snes_reg_wr_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = reg_off_s;
            wr_data_s = SNES_DATA_IN;
        end else if (mcu_commit_s) begin
            wr_en_s   = (mcu_wr_idx <= 4'(NWIN));
            wr_idx_s  = mcu_wr_idx;
            wr_data_s = mcu_wr_data;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Register readback value selection (index 0 = ctrl, i+1 = bank i)
    always_comb begin
        rd_val_s = 8'h00;
        if (reg_off_s == 4'd0) begin
            rd_val_s = ctrl_r;
        end else begin
            for (int i = 0; i < NWIN; i++) begin
                if (reg_off_s == 4'(i + 1)) begin
                    if (FIX_W0 && i == 0) begin
                        rd_val_s = 8'h00;
                    end else begin
                        rd_val_s = 8'(bank_r[i]);
                    end
                end else begin
                    rd_val_s = rd_val_s;
                end
            end
        end
    end

    // ROM window and SRAM window address translation
    always_comb begin
        win_s      = WSEL_W'(SNES_ADDR[21:0] >> WOFF_W);
        rom_bank_s = (FIX_W0 && win_s == '0) ? '0 : bank_r[win_s];
        in_rom_s   = (SNES_ADDR[23:22] == 2'b11);
        in_sram_s  = !SNES_ADDR[22] && SNES_ADDR[21] && (SNES_ADDR[15:13] == 3'b011)
                     && ctrl_r[7] && SAVERAM_MASK[0];
        rom_map_s  = ((24'(rom_bank_s) << WOFF_W) | (SNES_ADDR & OFF_MASK)) & ROM_MASK;
        sram_map_s = 24'hE00000 + ({6'd0, SNES_ADDR[20:16], SNES_ADDR[12:0]} & SAVERAM_MASK);
    end

    // Register file and MCU acknowledge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_r <= 8'h00;
            ack_r  <= 1'b0;
            for (int i = 0; i < NWIN; i++) begin
                bank_r[i] <= BANK_W'(i);
            end
        end else begin
            ack_r <= mcu_commit_s;
            if (wr_en_s) begin
                if (wr_idx_s == 4'd0) begin
                    ctrl_r <= wr_data_s;
                end else begin
                    for (int i = 0; i < NWIN; i++) begin
                        if (wr_idx_s == 4'(i + 1) && !(FIX_W0 && i == 0)) begin
                            bank_r[i] <= wr_data_s[BANK_W-1:0];
                        end else begin
                            bank_r[i] <= bank_r[i];
                        end
                    end
                end
            end else begin
                ctrl_r <= ctrl_r;
            end
        end
    end

    // Registered decode outputs and readback
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rom_addr_r   <= 24'h000000;
            rom_hit_r    <= 1'b0;
            is_saveram_r <= 1'b0;
            reg_rd_hit_r <= 1'b0;
            data_out_r   <= 8'h00;
        end else begin
            if (in_rom_s) begin
                rom_addr_r   <= rom_map_s;
                rom_hit_r    <= 1'b1;
                is_saveram_r <= 1'b0;
            end else if (in_sram_s) begin
                rom_addr_r   <= sram_map_s;
                rom_hit_r    <= 1'b1;
                is_saveram_r <= 1'b1;
            end else begin
                rom_addr_r   <= 24'h000000;
                rom_hit_r    <= 1'b0;
                is_saveram_r <= 1'b0;
            end
            if (SNES_RD_PULSE) begin
                reg_rd_hit_r <= reg_sel_s;
                data_out_r   <= reg_sel_s ? rd_val_s : 8'h00;
            end else begin
                reg_rd_hit_r <= reg_rd_hit_r;
                data_out_r   <= data_out_r;
            end
        end
    end

    assign mcu_wr_ack    = ack_r;
    assign ROM_ADDR      = rom_addr_r;
    assign ROM_HIT       = rom_hit_r;
    assign IS_SAVERAM    = is_saveram_r;
    assign reg_rd_hit    = reg_rd_hit_r;
    assign SNES_DATA_OUT = data_out_r;

endmodule

// File: tb/tb_spc7110_bank_map.sv
// Bench for spc7110_bank_map: arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_spc7110_bank_map;

    localparam int NWIN   = 4;
    localparam int BANK_W = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [23:0] SNES_ADDR = 24'h0;
    logic [7:0]  SNES_DATA_IN = 8'h0;
    logic        SNES_WR_PULSE = 1'b0;
    logic        SNES_RD_PULSE = 1'b0;
    logic [23:0] ROM_MASK = 24'hFFFFFF;
    logic [23:0] SAVERAM_MASK = 24'h0;
    logic        mcu_wr_req = 1'b0;
    logic [3:0]  mcu_wr_idx = 4'd0;
    logic [7:0]  mcu_wr_data = 8'h0;
    logic        mcu_wr_ack;
    logic [23:0] ROM_ADDR;
    logic        ROM_HIT;
    logic        IS_SAVERAM;
    logic        reg_rd_hit;
    logic [7:0]  SNES_DATA_OUT;

    int npass = 0;
    int ntot  = 0;
    bit chk_en = 1'b0;

    spc7110_bank_map #(.NWIN(NWIN), .BANK_W(BANK_W), .IO_BASE(16'h4830), .FIX_W0(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .SNES_ADDR(SNES_ADDR), .SNES_DATA_IN(SNES_DATA_IN),
        .SNES_WR_PULSE(SNES_WR_PULSE), .SNES_RD_PULSE(SNES_RD_PULSE), .ROM_MASK(ROM_MASK),
        .SAVERAM_MASK(SAVERAM_MASK), .mcu_wr_req(mcu_wr_req), .mcu_wr_idx(mcu_wr_idx),
        .mcu_wr_data(mcu_wr_data), .mcu_wr_ack(mcu_wr_ack), .ROM_ADDR(ROM_ADDR),
        .ROM_HIT(ROM_HIT), .IS_SAVERAM(IS_SAVERAM), .reg_rd_hit(reg_rd_hit),
        .SNES_DATA_OUT(SNES_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model state
    int   bank_m [NWIN];
    int   ctrl_m;
    bit   ack_m;
    int   e_addr;
    bit   e_hit, e_sav, e_rhit;
    int   e_data;

    function automatic bit m_isreg(input logic [23:0] a);
        int lo;
        lo = int'(a) % 65536;
        return (a[22] == 1'b0) && lo >= 'h4830 && lo <= 'h4830 + NWIN;
    endfunction

    function automatic int m_regval(input int off);
        if (off == 0) return ctrl_m;
        if (off == 1) return 0;
        return bank_m[off - 1];
    endfunction

    function automatic int m_rom(input logic [23:0] a, input logic [23:0] rmask);
        int winsz, rel;
        winsz = 'h400000 / NWIN;
        rel   = int'(a) - 'hC00000;
        return ((((rel / winsz) == 0) ? 0 : bank_m[rel / winsz]) * winsz + rel % winsz) & int'(rmask);
    endfunction

    function automatic bit m_isram(input logic [23:0] a);
        return ((int'(a) >> 21) % 4 == 1) && ((int'(a) >> 13) % 8 == 3)
               && (ctrl_m >= 128) && SAVERAM_MASK[0];
    endfunction

    function automatic int m_sram(input logic [23:0] a);
        return 'hE00000 + ((((int'(a) >> 16) % 32) * 8192 + int'(a) % 8192) & int'(SAVERAM_MASK));
    endfunction

    function automatic bit m_snes_wr();
        return SNES_WR_PULSE && m_isreg(SNES_ADDR);
    endfunction

    function automatic bit m_commit();
        return mcu_wr_req && !ack_m && !m_snes_wr();
    endfunction

    function automatic int m_widx();
        return m_snes_wr() ? (int'(SNES_ADDR) % 65536 - 'h4830) : int'(mcu_wr_idx);
    endfunction

    function automatic int m_wdata();
        return m_snes_wr() ? int'(SNES_DATA_IN) : int'(mcu_wr_data);
    endfunction

    // Reference model: expected outputs from the inputs seen at each edge, old register values
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ctrl_m <= 0;
            bank_m <= '{0, 1, 2, 3};
            ack_m  <= 1'b0;
            e_addr <= 0; e_hit <= 1'b0; e_sav <= 1'b0; e_rhit <= 1'b0; e_data <= 0;
        end else begin
            if (SNES_ADDR[23:22] == 2'b11) begin
                e_addr <= m_rom(SNES_ADDR, ROM_MASK); e_hit <= 1'b1; e_sav <= 1'b0;
            end else if (m_isram(SNES_ADDR)) begin
                e_addr <= m_sram(SNES_ADDR); e_hit <= 1'b1; e_sav <= 1'b1;
            end else begin
                e_addr <= 0; e_hit <= 1'b0; e_sav <= 1'b0;
            end
            if (SNES_RD_PULSE) begin
                e_rhit <= m_isreg(SNES_ADDR);
                e_data <= m_isreg(SNES_ADDR) ? m_regval(int'(SNES_ADDR) % 65536 - 'h4830) : 0;
            end
            if (m_snes_wr() || (m_commit() && mcu_wr_idx <= NWIN)) begin
                if (m_widx() == 0) ctrl_m <= m_wdata();
                else if (m_widx() > 1) bank_m[m_widx() - 1] <= m_wdata() % (1 << BANK_W);
            end
            ack_m <= m_commit();
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_rom_addr", 32'(ROM_ADDR), 32'(e_addr));
            check("model_rom_hit", 32'(ROM_HIT), 32'(e_hit));
            check("model_is_saveram", 32'(IS_SAVERAM), 32'(e_sav));
            check("model_reg_rd_hit", 32'(reg_rd_hit), 32'(e_rhit));
            check("model_ack", 32'(mcu_wr_ack), 32'(ack_m));
            if (e_rhit) check("model_data_out", 32'(SNES_DATA_OUT), 32'(e_data));
        end
    end

    task automatic step(input logic [23:0] a, input bit wr = 1'b0, input bit rd = 1'b0,
                        input logic [7:0] d = 8'h00);
        SNES_ADDR     = a;
        SNES_WR_PULSE = wr;
        SNES_RD_PULSE = rd;
        SNES_DATA_IN  = d;
        @(negedge CLK);
        SNES_WR_PULSE = 1'b0;
        SNES_RD_PULSE = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rom_addr"}, 32'(ROM_ADDR), 32'h0);
        check({tag, "_rom_hit"}, 32'(ROM_HIT), 32'h0);
        check({tag, "_is_saveram"}, 32'(IS_SAVERAM), 32'h0);
        check({tag, "_reg_rd_hit"}, 32'(reg_rd_hit), 32'h0);
        check({tag, "_data_out"}, 32'(SNES_DATA_OUT), 32'h0);
        check({tag, "_ack"}, 32'(mcu_wr_ack), 32'h0);
    endtask

    initial begin
        #2 RST_N = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge CLK);
        #2 RST_N = 1'b1;
        chk_en = 1'b1;

        // Identity map out of reset
        step(24'hD01234);
        check("ident_d0", 32'(ROM_ADDR), 32'h101234);
        check("ident_d0_hit", 32'(ROM_HIT), 32'h1);
        step(24'hC0ABCD);
        check("ident_c0", 32'(ROM_ADDR), 32'h00ABCD);

        // SNES bank write, readback and ROM mask
        step(24'h004833, 1'b1, 1'b0, 8'h05);
        step(24'hE00010);
        check("bank2_map", 32'(ROM_ADDR), 32'h500010);
        step(24'h004833, 1'b0, 1'b1);
        check("bank2_read", 32'(SNES_DATA_OUT), 32'h05);
        check("bank2_read_hit", 32'(reg_rd_hit), 32'h1);
        ROM_MASK = 24'h3FFFFF;
        step(24'hE00010);
        check("rom_mask", 32'(ROM_ADDR), 32'h100010);
        ROM_MASK = 24'hFFFFFF;

        // SRAM gating
        SAVERAM_MASK = 24'h001FFF;
        step(24'h306005);
        check("sram_ctrl_off", 32'(ROM_HIT), 32'h0);
        step(24'h004830, 1'b1, 1'b0, 8'h80);
        step(24'h306005);
        check("sram_addr", 32'(ROM_ADDR), 32'hE00005);
        check("sram_is_saveram", 32'(IS_SAVERAM), 32'h1);
        SAVERAM_MASK = 24'h001FFE;
        step(24'h306005);
        check("sram_absent", 32'(ROM_HIT), 32'h0);
        SAVERAM_MASK = 24'h001FFF;

        // MCU handshake; req held through the ack cycle with different data
        mcu_wr_req = 1'b1; mcu_wr_idx = 4'd4; mcu_wr_data = 8'h07;
        step(24'hF00000);
        check("mcu_ack", 32'(mcu_wr_ack), 32'h1);
        check("mcu_same_cycle_old", 32'(ROM_ADDR), 32'h300000);
        mcu_wr_data = 8'h03;
        step(24'hF00000);
        check("mcu_ack_drop", 32'(mcu_wr_ack), 32'h0);
        check("mcu_bank3_map", 32'(ROM_ADDR), 32'h700000);
        mcu_wr_req = 1'b0;
        step(24'hF00000);
        check("mcu_no_second", 32'(ROM_ADDR), 32'h700000);

        // Out-of-range idx is acknowledged and discarded
        mcu_wr_req = 1'b1; mcu_wr_idx = 4'd9; mcu_wr_data = 8'h01;
        step(24'hC00000);
        check("mcu_idx9_ack", 32'(mcu_wr_ack), 32'h1);
        mcu_wr_req = 1'b0;
        step(24'h004834, 1'b0, 1'b1);
        check("mcu_idx9_nochange", 32'(SNES_DATA_OUT), 32'h07);

        // Collision: SNES wins this edge, MCU commits next edge
        mcu_wr_req = 1'b1; mcu_wr_idx = 4'd3; mcu_wr_data = 8'h06;
        step(24'h004833, 1'b1, 1'b0, 8'h02);
        check("coll_no_ack", 32'(mcu_wr_ack), 32'h0);
        step(24'h004833, 1'b0, 1'b1);
        check("coll_snes_value", 32'(SNES_DATA_OUT), 32'h02);
        check("coll_ack", 32'(mcu_wr_ack), 32'h1);
        mcu_wr_req = 1'b0;
        step(24'h004833, 1'b0, 1'b1);
        check("coll_mcu_value", 32'(SNES_DATA_OUT), 32'h06);

        // Fixed window 0
        step(24'h004831, 1'b1, 1'b0, 8'h05);
        step(24'hC01234);
        check("fix_w0_map", 32'(ROM_ADDR), 32'h001234);
        step(24'h004831, 1'b0, 1'b1);
        check("fix_w0_read", 32'(SNES_DATA_OUT), 32'h00);
        step(24'hC00000, 1'b0, 1'b1);
        check("rd_nonreg_clear", 32'(reg_rd_hit), 32'h0);

        // Reset in the middle of a pending request
        step(24'h004834, 1'b1, 1'b0, 8'h01);
        step(24'hF00000);
        check("pre_reset_bank3", 32'(ROM_ADDR), 32'h100000);
        mcu_wr_req = 1'b1; mcu_wr_idx = 4'd0; mcu_wr_data = 8'h80;
        #2 RST_N = 1'b0;
        #1 check_zero("midreset");
        mcu_wr_req = 1'b0;
        #1 RST_N = 1'b1;
        SNES_ADDR = 24'hF00000;
        @(negedge CLK);
        check("post_reset_ack", 32'(mcu_wr_ack), 32'h0);
        check("post_reset_map", 32'(ROM_ADDR), 32'h300000);
        step(24'h004830, 1'b0, 1'b1);
        check("post_reset_ctrl", 32'(SNES_DATA_OUT), 32'h00);
        check("post_reset_ack2", 32'(mcu_wr_ack), 32'h0);

        repeat (2) @(negedge CLK);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
